// File: rtl/multicycle_control_if.sv
// Handshake bundle between the multicycle control FSM and the datapath/memory side.
// The slave side is the controller; the master side drives opcode and memory status.
interface multicycle_control_if #(
  parameter int OPW = 6
);
  logic [OPW-1:0] opcode;
  logic           mem_ready;
  logic           trap_ack;
  logic [10:0]    control_signal;
  logic           ifetch;
  logic           ir_write;
  logic           pc_write;
  logic           mem_byte;
  logic           instr_done;
  logic [2:0]     state;

  modport master (
    output opcode, mem_ready, trap_ack,
    input  control_signal, ifetch, ir_write, pc_write, mem_byte, instr_done, state
  );

  modport slave (
    input  opcode, mem_ready, trap_ack,
    output control_signal, ifetch, ir_write, pc_write, mem_byte, instr_done, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// wait timeout and an illegal-opcode trap. Control word is decoded from state and latched opcode.
module multicycle_control #(
  parameter int OPW          = 6,
  parameter int TO_W         = 4,
  parameter int MEM_TIMEOUT  = 15,
  parameter bit EN_SB        = 1'b1,
  parameter bit EN_IMM_LOGIC = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_J    = OPW'(2);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(4);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(5);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(8);
  localparam logic [OPW-1:0] OP_SLTI = OPW'(10);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(12);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(13);
  localparam logic [OPW-1:0] OP_LW   = OPW'(35);
  localparam logic [OPW-1:0] OP_SB   = OPW'(40);
  localparam logic [OPW-1:0] OP_SW   = OPW'(43);

  state_e          state_q;
  logic [OPW-1:0]  op_q;
  logic [TO_W-1:0] wait_q;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    case (op)
      OP_R, OP_ADDI, OP_LW, OP_SW, OP_J, OP_BEQ, OP_BNE: op_legal = 1'b1;
      OP_SB:                                             op_legal = EN_SB;
      OP_SLTI, OP_ANDI, OP_ORI:                          op_legal = EN_IMM_LOGIC;
      default:                                           op_legal = 1'b0;
    endcase
  endfunction

  logic is_r, is_lw, is_sw, is_sb, is_j, is_br, is_imm, is_addi, is_mem, timed_out;
  assign is_r      = (op_q == OP_R);
  assign is_lw     = (op_q == OP_LW);
  assign is_sw     = (op_q == OP_SW);
  assign is_sb     = (op_q == OP_SB);
  assign is_j      = (op_q == OP_J);
  assign is_br     = (op_q == OP_BEQ) || (op_q == OP_BNE);
  assign is_imm    = (op_q == OP_SLTI) || (op_q == OP_ANDI) || (op_q == OP_ORI);
  assign is_addi   = (op_q == OP_ADDI);
  assign is_mem    = is_lw || is_sw || is_sb;
  assign timed_out = (wait_q == TO_W'(MEM_TIMEOUT));

  // wait_q defaults to zero so it clears on every state change; only a stall in FETCH/MEM keeps counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      wait_q <= '0;
      case (state_q)
        S_FETCH, S_MEM: begin
          if (bus.mem_ready) begin
            if (state_q == S_FETCH) state_q <= S_DECODE;
            else if (is_lw)         state_q <= S_WB;
            else                    state_q <= S_FETCH;
          end else if (timed_out) begin
            state_q <= S_TRAP;
          end else begin
            wait_q <= wait_q + TO_W'(1);
          end
        end
        S_DECODE: begin
          op_q    <= bus.opcode;
          state_q <= op_legal(bus.opcode) ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          if (is_j || is_br) state_q <= S_FETCH;
          else if (is_mem)   state_q <= S_MEM;
          else               state_q <= S_WB;
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  if (bus.trap_ack) state_q <= S_FETCH;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  logic [1:0] alu_op;
  logic       alu_src;
  always_comb begin
    alu_op = 2'b00;
    if (is_r)        alu_op = 2'b10;
    else if (is_br)  alu_op = 2'b01;
    else if (is_imm) alu_op = 2'b11;
  end
  assign alu_src = is_mem || is_addi || is_imm;

  // ir_write/pc_write/instr_done mark the completing cycle of a memory wait, so they follow mem_ready there
  always_comb begin
    bus.control_signal = '0;
    bus.ifetch         = 1'b0;
    bus.ir_write       = 1'b0;
    bus.pc_write       = 1'b0;
    bus.mem_byte       = 1'b0;
    bus.instr_done     = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.ifetch   = 1'b1;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
      end
      S_EXEC: begin
        bus.control_signal[5:4] = alu_op;
        bus.control_signal[2]   = alu_src;
        bus.control_signal[10]  = is_j;
        bus.control_signal[9]   = is_br;
        bus.pc_write            = is_j;
        bus.instr_done          = is_j || is_br;
      end
      S_MEM: begin
        bus.control_signal[2] = 1'b1;
        bus.control_signal[8] = is_lw;
        bus.control_signal[7] = is_sw || is_sb;
        bus.mem_byte          = is_sb;
        bus.instr_done        = bus.mem_ready && (is_sw || is_sb);
      end
      S_WB: begin
        bus.control_signal[5:4] = alu_op;
        bus.control_signal[2]   = alu_src;
        bus.control_signal[6]   = is_lw;
        bus.control_signal[1]   = 1'b1;
        bus.control_signal[0]   = is_r;
        bus.instr_done          = 1'b1;
      end
      S_TRAP:  bus.control_signal[3] = 1'b1;
      default: ;
    endcase
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against an instruction-level reference of the control FSM,
// plus directed reset, timeout-boundary and disabled-opcode checks.
module tb_multicycle_control;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if #(.OPW(6)) bus ();
  multicycle_control_if #(.OPW(6)) bus2 ();

  multicycle_control #(.OPW(6), .TO_W(4), .MEM_TIMEOUT(TO), .EN_SB(1'b1), .EN_IMM_LOGIC(1'b1))
    dut (.clk(clk), .rst(rst), .bus(bus));
  multicycle_control #(.OPW(6), .TO_W(4), .MEM_TIMEOUT(TO), .EN_SB(1'b0), .EN_IMM_LOGIC(1'b0))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction
  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // misc = {ifetch, ir_write, pc_write, mem_byte, instr_done}
  task automatic cyc(input logic [5:0] op, input logic mr, input logic ack, input logic [2:0] st,
                     input logic [10:0] cs, input logic [4:0] misc, input string tag);
    bus.opcode = op; bus.mem_ready = mr; bus.trap_ack = ack;
    #1;
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".cs"}, 32'(bus.control_signal), 32'(cs));
    chk({tag, ".misc"}, 32'({bus.ifetch, bus.ir_write, bus.pc_write, bus.mem_byte, bus.instr_done}),
        32'(misc));
    @(negedge clk);
  endtask

  task automatic cyc2(input logic [5:0] op, input logic mr, input logic ack, input logic [2:0] st,
                      input logic [10:0] cs, input logic [4:0] misc, input string tag);
    bus2.opcode = op; bus2.mem_ready = mr; bus2.trap_ack = ack;
    #1;
    chk({tag, ".state"}, 32'(bus2.state), 32'(st));
    chk({tag, ".cs"}, 32'(bus2.control_signal), 32'(cs));
    chk({tag, ".misc"}, 32'({bus2.ifetch, bus2.ir_write, bus2.pc_write, bus2.mem_byte, bus2.instr_done}),
        32'(misc));
    @(negedge clk);
  endtask

  task automatic trap(input int ackd);
    for (int i = 0; i < ackd; i++) cyc(rop(), rbit(), 1'b0, 3'd5, 11'h008, 5'b00000, "trap_hold");
    cyc(rop(), rbit(), 1'b1, 3'd5, 11'h008, 5'b00000, "trap_ack");
  endtask

  // One instruction: flat/mlat = low mem_ready cycles before the grant; > TO low cycles means trap.
  task automatic run_instr(input logic [5:0] op, input int flat, input int mlat, input int ackd);
    logic [10:0] ex, mw, wb;
    logic legal, isj, isbr, ismem, isld, issb;
    ex = '0; mw = '0; wb = '0;
    legal = 1'b1; isj = 1'b0; isbr = 1'b0; ismem = 1'b0; isld = 1'b0; issb = 1'b0;
    case (op)
      6'd0:               begin ex = 11'h020; wb = 11'h023; end
      6'd8:               begin ex = 11'h004; wb = 11'h006; end
      6'd35:              begin ex = 11'h004; mw = 11'h104; wb = 11'h046; ismem = 1'b1; isld = 1'b1; end
      6'd43:              begin ex = 11'h004; mw = 11'h084; ismem = 1'b1; end
      6'd40:              begin ex = 11'h004; mw = 11'h084; ismem = 1'b1; issb = 1'b1; end
      6'd2:               begin ex = 11'h400; isj = 1'b1; end
      6'd4, 6'd5:         begin ex = 11'h210; isbr = 1'b1; end
      6'd10, 6'd12, 6'd13: begin ex = 11'h034; wb = 11'h036; end
      default:            legal = 1'b0;
    endcase
    for (int i = 0; i < flat && i <= TO; i++)
      cyc(rop(), 1'b0, rbit(), 3'd0, 11'h000, 5'b10000, "fetch_wait");
    if (flat > TO) begin trap(ackd); return; end
    cyc(rop(), 1'b1, rbit(), 3'd0, 11'h000, 5'b11100, "fetch");
    cyc(op, rbit(), rbit(), 3'd1, 11'h000, 5'b00000, "decode");
    if (!legal) begin trap(ackd); return; end
    cyc(rop(), rbit(), rbit(), 3'd2, ex, {2'b00, isj, 1'b0, isj | isbr}, "exec");
    if (isj || isbr) return;
    if (ismem) begin
      for (int i = 0; i < mlat && i <= TO; i++)
        cyc(rop(), 1'b0, rbit(), 3'd3, mw, {3'b000, issb, 1'b0}, "mem_wait");
      if (mlat > TO) begin trap(ackd); return; end
      cyc(rop(), 1'b1, rbit(), 3'd3, mw, {3'b000, issb, ~isld}, "mem");
      if (!isld) return;
    end
    cyc(rop(), rbit(), rbit(), 3'd4, wb, 5'b00001, "wb");
  endtask

  logic [5:0] legal_ops [11] = '{6'd0, 6'd8, 6'd35, 6'd43, 6'd40, 6'd2, 6'd4, 6'd5, 6'd10, 6'd12, 6'd13};

  initial begin
    bus.opcode = '0; bus.mem_ready = 1'b0; bus.trap_ack = 1'b0;
    bus2.opcode = '0; bus2.mem_ready = 1'b0; bus2.trap_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.state", 32'(bus.state), 32'd0);
    chk("reset.cs", 32'(bus.control_signal), 32'd0);
    chk("reset.misc", 32'({bus.ifetch, bus.ir_write, bus.pc_write, bus.mem_byte, bus.instr_done}),
        32'b10000);
    @(negedge clk);
    rst = 1'b0;

    run_instr(6'd0, 0, 0, 0);
    run_instr(6'd35, 0, 3, 0);
    run_instr(6'd2, 1, 0, 0);
    run_instr(6'd4, 0, 0, 0);
    run_instr(6'd40, 2, 1, 0);
    run_instr(6'd0, 15, 0, 0);
    run_instr(6'd0, 16, 0, 2);
    run_instr(6'd43, 0, 15, 0);
    run_instr(6'd35, 1, 16, 1);
    run_instr(6'd63, 0, 0, 3);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      int flat, mlat;
      op   = ($urandom_range(0, 4) == 0) ? rop() : legal_ops[$urandom_range(0, 10)];
      flat = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 2);
      mlat = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      run_instr(op, flat, mlat, $urandom_range(0, 3));
    end

    // asynchronous reset in the middle of a store's memory wait
    cyc(rop(), 1'b1, 1'b0, 3'd0, 11'h000, 5'b11100, "rst_fetch");
    cyc(6'd43, 1'b0, 1'b0, 3'd1, 11'h000, 5'b00000, "rst_decode");
    cyc(rop(), 1'b0, 1'b0, 3'd2, 11'h004, 5'b00000, "rst_exec");
    cyc(rop(), 1'b0, 1'b0, 3'd3, 11'h084, 5'b00000, "rst_mem");
    #2 rst = 1'b1;
    #1;
    chk("async_rst.state", 32'(bus.state), 32'd0);
    chk("async_rst.cs", 32'(bus.control_signal), 32'd0);
    chk("async_rst.misc", 32'({bus.ifetch, bus.ir_write, bus.pc_write, bus.mem_byte, bus.instr_done}),
        32'b10000);
    @(negedge clk);
    rst = 1'b0;

    // optional opcodes disabled: sb and andi trap, addi still legal
    cyc2(6'd0, 1'b1, 1'b0, 3'd0, 11'h000, 5'b11100, "d2_fetch");
    cyc2(6'd40, 1'b0, 1'b0, 3'd1, 11'h000, 5'b00000, "d2_decode_sb");
    for (int i = 0; i < 3; i++) cyc2(6'd0, 1'b1, 1'b0, 3'd5, 11'h008, 5'b00000, "d2_trap_sb");
    cyc2(6'd0, 1'b0, 1'b1, 3'd5, 11'h008, 5'b00000, "d2_ack_sb");
    cyc2(6'd0, 1'b1, 1'b1, 3'd0, 11'h000, 5'b11100, "d2_fetch2");
    cyc2(6'd12, 1'b0, 1'b0, 3'd1, 11'h000, 5'b00000, "d2_decode_andi");
    cyc2(6'd0, 1'b0, 1'b1, 3'd5, 11'h008, 5'b00000, "d2_ack_andi");
    cyc2(6'd0, 1'b1, 1'b0, 3'd0, 11'h000, 5'b11100, "d2_fetch3");
    cyc2(6'd8, 1'b0, 1'b0, 3'd1, 11'h000, 5'b00000, "d2_decode_addi");
    cyc2(6'd0, 1'b0, 1'b0, 3'd2, 11'h004, 5'b00000, "d2_exec_addi");
    cyc2(6'd0, 1'b0, 1'b0, 3'd4, 11'h006, 5'b00001, "d2_wb_addi");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
